// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU request/response core.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    ALU_ST_IDLE    = 2'd0,
    ALU_ST_MUL_RUN = 2'd1,
    ALU_ST_DONE    = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_if.sv
// Request/response bundle between an ALU requester (master) and alu_core (slave).
interface alu_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   operand_a;
  logic [WIDTH-1:0]   operand_b;
  logic [1:0]         operand;
  logic               op_valid;
  logic               operation_done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output operand_a, operand_b, operand, op_valid,
    input  operation_done, result
  );

  modport slave (
    input  operand_a, operand_b, operand, op_valid,
    output operation_done, result
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle, WIDTH cycles.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clock,
  input  logic               resetr,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    count_reg;
  logic [RW-1:0]    acc_reg;
  logic [RW-1:0]    mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic             busy_reg;
  logic [RW-1:0]    addend;

  // product is the accumulator after the current iteration, so on the final
  // iteration (done=1) it already holds the full product for the caller to latch.
  assign addend  = mplier_reg[0] ? mcand_reg : '0;
  assign product = acc_reg + addend;
  assign done    = busy_reg && (count_reg == CW'(WIDTH - 1));
  assign busy    = busy_reg;

  always_ff @(posedge clock or posedge resetr) begin
    if (resetr) begin
      busy_reg   <= 1'b0;
      count_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
    end else if (start) begin
      busy_reg   <= 1'b1;
      count_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= RW'(a);
      mplier_reg <= b;
    end else if (busy_reg) begin
      acc_reg    <= product;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + 1'b1;
      if (done) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_core.sv
// ALU responder: single-cycle ADD/SUB/XOR, iterative MUL when ALU_MULTIPLY_EN is defined
// (otherwise MUL completes in one cycle with a zero result).
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic  clock,
  input logic  resetr,
  alu_if.slave bus
);
  localparam int RW = 2 * WIDTH;

  localparam logic [1:0] IDLE    = ALU_ST_IDLE;
  localparam logic [1:0] MUL_RUN = ALU_ST_MUL_RUN;
  localparam logic [1:0] DONE    = ALU_ST_DONE;

  logic [1:0]    state_reg;
  logic [RW-1:0] result_reg;
  logic          done_reg;
  logic [RW-1:0] single_next;
  logic          can_accept;
  alu_op_e       op_sel;

  assign op_sel     = alu_op_e'(bus.operand);
  assign can_accept = (state_reg == IDLE) || (state_reg == DONE);

  always_comb begin
    single_next = '0;
    case (op_sel)
      ALU_ADD: single_next = RW'(bus.operand_a) + RW'(bus.operand_b);
      ALU_SUB: single_next = RW'(bus.operand_a) - RW'(bus.operand_b);
      ALU_XOR: single_next = RW'(bus.operand_a ^ bus.operand_b);
      default: single_next = '0;
    endcase
  end

`ifdef ALU_MULTIPLY_EN
  logic          mul_start;
  logic          mul_busy;
  logic          mul_done;
  logic [RW-1:0] mul_product;

  assign mul_start = bus.op_valid && can_accept && (op_sel == ALU_MUL);

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clock   (clock),
    .resetr  (resetr),
    .start   (mul_start),
    .a       (bus.operand_a),
    .b       (bus.operand_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  always_ff @(posedge clock or posedge resetr) begin
    if (resetr) begin
      state_reg  <= IDLE;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (bus.op_valid) begin
`ifdef ALU_MULTIPLY_EN
            if (op_sel == ALU_MUL) begin
              state_reg <= MUL_RUN;
            end else begin
              state_reg  <= DONE;
              done_reg   <= 1'b1;
              result_reg <= single_next;
            end
`else
            state_reg  <= DONE;
            done_reg   <= 1'b1;
            result_reg <= single_next;
`endif
          end else begin
            state_reg <= IDLE;
          end
        end
        MUL_RUN: begin
`ifdef ALU_MULTIPLY_EN
          // Requests arriving mid-multiply are dropped silently.
          if (mul_done) begin
            state_reg  <= DONE;
            done_reg   <= 1'b1;
            result_reg <= mul_product;
          end else if (!mul_busy) begin
            state_reg <= IDLE;
          end
`else
          state_reg <= IDLE;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.result         = result_reg;
  assign bus.operation_done = done_reg;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: expectations queued at accept, checked when operation_done pulses.
module tb_alu_core;
  localparam int W = 8;

  typedef struct {
    logic [1:0]    op;
    logic [2*W-1:0] res;
    int            acc_cyc;
    int            lat;
  } exp_t;

  logic clock = 1'b0;
  logic resetr = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  alu_if #(.WIDTH(W)) bus ();

  alu_core #(.WIDTH(W)) dut (
    .clock  (clock),
    .resetr (resetr),
    .bus    (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [2*W-1:0] xa, xb;
    xa = {{W{1'b0}}, a};
    xb = {{W{1'b0}}, b};
    case (op)
      2'd0: return xa + xb;
      2'd1: return xa - xb;
`ifdef ALU_MULTIPLY_EN
      2'd2: return xa * xb;
`else
      2'd2: return '0;
`endif
      default: return xa ^ xb;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op);
`ifdef ALU_MULTIPLY_EN
    if (op == 2'd2) return W + 1;
`endif
    return 1;
  endfunction

  // Drive one request; it is accepted on the following rising edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge clock);
    bus.operand_a = a;
    bus.operand_b = b;
    bus.operand   = op;
    bus.op_valid  = 1'b1;
    @(posedge clock);
    #1;
    e.op      = op;
    e.res     = model(op, a, b);
    e.acc_cyc = cyc;
    e.lat     = model_lat(op);
    exp_q.push_back(e);
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clock);
    end
    check_val("drain_timeout", exp_q.size(), 0);
  endtask

  // Output monitor.
  always @(negedge clock) begin
    if (!resetr && bus.operation_done) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn op=%0d result=%h latency=%0d", e.op, bus.result, cyc - e.acc_cyc + 1);
        check_val("result", bus.result, e.res);
        check_val("latency", cyc - e.acc_cyc + 1, e.lat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.operand   = '0;
    bus.op_valid  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetr = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_val("idle_done", bus.operation_done, 0);
      check_val("idle_result", bus.result, 0);
    end

    issue(2'd0, 8'hFF, 8'h01);
    wait_idle();
    issue(2'd1, 8'd3, 8'd5);
    wait_idle();

    // Multiply with stray requests mid-run.
    issue(2'd2, 8'hFF, 8'hFF);
`ifdef ALU_MULTIPLY_EN
    repeat (2) @(negedge clock);
    bus.operand   = 2'd0;
    bus.op_valid  = 1'b1;
    repeat (2) @(negedge clock);
    bus.op_valid  = 1'b0;
`endif
    wait_idle();

    // Back-to-back: second request issued in the done cycle of the first.
    issue(2'd3, 8'hA5, 8'h5A);
    issue(2'd0, 8'd2, 8'd2);
    wait_idle();

    // Reset four cycles into a multiply.
    issue(2'd2, 8'hFF, 8'hFF);
    repeat (3) @(posedge clock);
    #1;
    resetr = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check_val("rst_done", bus.operation_done, 0);
    check_val("rst_result", bus.result, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetr = 1'b0;
    repeat (12) @(negedge clock);
    check_val("post_rst_result", bus.result, 0);
    issue(2'd0, 8'd1, 8'd1);
    wait_idle();

    issue(2'd2, 8'd7, 8'd6);
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      issue(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      wait_idle();
    end

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_core.md
# alu_core

Operation responder for the ALU request/response protocol. Accepts an operand pair and opcode qualified by `op_valid`, computes the result (single-cycle for add/sub/xor, iterative shift-add for multiply), and returns it on `result` qualified by a one-cycle `operation_done` pulse. It is the DUT that the bench's input driver and output monitor attach to. It sits directly under `top`.

## Interface
Parameters:
- `WIDTH`, 8: operand width; `result` is 2*WIDTH.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `resetr`  in  1  asynchronous, active-high reset.
- `operand_a`  in  WIDTH  first operand, sampled on accept.
- `operand_b`  in  WIDTH  second operand, sampled on accept.
- `operand`  in  2  opcode: 0 ADD, 1 SUB, 2 MUL, 3 XOR.
- `op_valid`  in  1  request strobe; qualifies operands and opcode.
- `operation_done`  out  1  one-cycle pulse; `result` valid this cycle.
- `result`  out  2*WIDTH  registered result; holds until the next completion.

## Operation
- FSM states: IDLE, MUL_RUN, DONE.
- Accept: `op_valid`=1 at a rising edge while in IDLE or DONE. Operands and opcode are latched. In MUL_RUN, `op_valid` is ignored with no effect and no error. The requester waits for `operation_done` before issuing the next request.
- ADD: `result` = zero-extended a + b. The carry lands in bit WIDTH.
- SUB: `result` = (2W-bit a) − (2W-bit b), mod 2^(2W). Example, W=8: 3−5 = 0xFFFE.
- XOR: `result` = zero-extended a ^ b.
- MUL: unsigned a*b, computed over exactly WIDTH iterations (one multiplier bit per cycle) in MUL_RUN.
- Transitions:
  - IDLE/DONE with accept of a non-MUL op → DONE.
  - IDLE/DONE with accept of MUL → MUL_RUN.
  - MUL_RUN after the WIDTH-th iteration → DONE.
  - DONE without accept → IDLE.
- `result` updates only on entry to DONE. Intermediate multiply partial products never appear on `result`.

## Timing
- Reset values: `operation_done`=0, `result`=0, state IDLE, multiplier counter 0.
- Non-MUL latency: accept at edge N, then `operation_done`=1 during cycle N+1 (after edge N+1... registered at edge N+1 as seen by the monitor on the next sampling edge). Latency is one cycle.
- MUL latency: accept at edge N, then `operation_done`=1 after edge N+WIDTH+1. Example: 9 cycles for WIDTH=8.
- Back-to-back: a request accepted in the same cycle `operation_done` is high is legal. `operation_done` then pulses again 1 cycle (or WIDTH+1 cycles for MUL) later. For consecutive single-cycle ops, `operation_done` may stay high continuously, one result per cycle.
- `operation_done` is never high for two cycles for one request.
- Reset mid-operation aborts the operation immediately. No `operation_done` follows, and `result` clears to 0.
- Multiply wrap: none possible, since 2*WIDTH holds the full product. Example, W=8: 0xFF*0xFF = 0xFE01.

## Configuration
- `ALU_MULTIPLY_EN` defined: MUL implemented as above through the iterative sub-module.
- `ALU_MULTIPLY_EN` undefined:
  - The multiplier and MUL_RUN are compiled out.
  - Opcode 2 completes with single-cycle latency and `result`=0.
  - All other opcodes and timing are unchanged.

## Structure
- `alu_pkg`: opcode enum (`ALU_ADD`, `ALU_SUB`, `ALU_MUL`, `ALU_XOR`), FSM state enum, default `WIDTH` constant.
- Sub-module `alu_mul_seq`: shift-add multiplier with `start`, `a`, `b`, `busy`, `done`, `product`, an iteration counter of $clog2(WIDTH+1) bits, and the same `clock`/`resetr`. Instantiated only under `ALU_MULTIPLY_EN`.
- `alu_core`: FSM, operand latches, single-cycle datapath, `result`/`operation_done` registers.

## Test plan
- Reset then idle 10 cycles: `operation_done`=0 and `result`=0 throughout.
- ADD a=0xFF, b=0x01: `operation_done` one cycle after accept, `result`=0x0100. Then SUB a=3, b=5: `result`=0xFFFE.
- MUL a=0xFF, b=0xFF (W=8): exactly 9 cycles to `operation_done`, `result`=0xFE01. Extra `op_valid` pulses mid-run are ignored and produce no extra done.
- Back-to-back XOR 0xA5^0x5A, then ADD 2+2 issued in the done cycle: two consecutive done pulses, `result`=0x00FF then 0x0004.
- Assert `resetr` 4 cycles into a MUL: no `operation_done`, `result`=0. A subsequent ADD 1+1 returns 0x0002 normally.
- Build without `ALU_MULTIPLY_EN`: MUL 7*6 gives done after 1 cycle with `result`=0.
